vga_timing_detector: RTL and testbench
======================================

VGA_TIMING_DETECTOR -- requirements
Module: vga_timing_detector

Interface
REQ-001 Parameter: LOCK_FRAMES, 2, consecutive identical frame measurements required to assert lock (legal 1..15).
REQ-002 vga_clk  input  1  pixel clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 HSYNC_Sig  input  1  horizontal sync, active-low.
REQ-005 VSYNC_Sig  input  1  vertical sync, active-low.
REQ-006 Ready_Sig  input  1  active-video (data-enable) qualifier, active-high.
REQ-007 Ready_Out  output  1  Ready_Sig delayed exactly 2 vga_clk cycles.
REQ-008 Column_Addr_Sig  output  11  recovered pixel column, aligned with Ready_Out.
REQ-009 Row_Addr_Sig  output  11  recovered active row, aligned with Ready_Out.
REQ-010 H_Total, H_Active, V_Total, V_Active  output  12 each  locked timing measurement.
REQ-011 Locked  output  1  timing stable.
REQ-012 Frame_Start  output  1  one-cycle pulse per detected frame.

Function
REQ-013 All three inputs SHALL be registered once; edges SHALL be detected from this registered copy and its 1-cycle-delayed copy.
REQ-014 Line start = HSYNC falling edge (hfall); frame start = VSYNC falling edge (vfall).
REQ-015 h_cnt SHALL count cycles since last hfall; on hfall, line period (cycles between consecutive hfalls) SHALL be captured and h_cnt restarted.
REQ-016 Per line, cycles with registered Ready high SHALL be counted; captured as line active width on hfall.
REQ-017 v_cnt SHALL increment on each hfall; a line containing at least one Ready cycle SHALL increment the active-line count on its closing hfall.
REQ-018 On vfall, frame measurement {last line period, last active width, v_cnt, active lines} SHALL be snapshotted, including a coincident hfall counted in the ending frame; v_cnt and active-line count then restart at 0.
REQ-019 Frame_Start SHALL pulse the cycle after each vfall detection, in all FSM states.
REQ-020 FSM states: SEARCH, MEASURE, LOCKED.
REQ-021 SEARCH -> MEASURE on first vfall (snapshot stored, match count 0).
REQ-022 MEASURE: on vfall, snapshot equal to previous -> match count +1, else match count 0; previous snapshot always replaced; match count reaching LOCK_FRAMES -> LOCKED.
REQ-023 On entering LOCKED, H_Total/H_Active/V_Total/V_Active SHALL load the snapshot and Locked SHALL assert in the same cycle.
REQ-024 LOCKED: on vfall with differing snapshot -> SEARCH, Locked deasserts next cycle; measurement outputs hold last locked values.
REQ-025 Loss of signal: h_cnt reaching 4095 (saturating, no wrap) SHALL force SEARCH from any state and clear match count.
REQ-026 Column_Addr_Sig = count of Ready cycles earlier in current line (first active pixel = 0); Row_Addr_Sig = active lines completed in current frame; both 0 whenever Ready_Out is low.
REQ-027 Address counters SHALL saturate at 2047; saturation SHALL NOT affect measurement counters.
REQ-028 Addresses and Ready_Out SHALL operate regardless of Locked.

Reset
REQ-029 While rst high: FSM = SEARCH, all counters, snapshots and match count 0; all outputs 0; input registers 0 (first edge detection after reset sees no falling edge).
REQ-030 Reset asserted mid-frame SHALL abort measurement; lock requires LOCK_FRAMES+1 full frames after release.

Verification
REQ-031 Stable timing (line 100 cycles, Ready 64, frame 20 lines, 12 active), LOCK_FRAMES=2 -> Locked rises at third vfall after reset; outputs 100/64/20/12.
REQ-032 Same stream -> first active pixel of each line Column=0, last Column=63; Row runs 0..11; addresses 0 outside Ready_Out; Ready_Out = Ready_Sig delayed 2.
REQ-033 While locked, one frame of 21 lines -> Locked drops after that vfall, outputs stay 100/64/20/12; relock after LOCK_FRAMES matching 21-line frames with V_Total=21.
REQ-034 HSYNC held high 4096 cycles -> FSM SEARCH, Locked 0; restart timing -> relock as REQ-031.
REQ-035 hfall and vfall same cycle -> that line counted in ending frame; V_Total unchanged at 20.
REQ-036 rst pulsed mid-frame while locked -> all outputs 0 next cycle; relock per REQ-030.

Source files
------------

// File: rtl/vga_timing_detector.sv
// VGA timing detector: measures line/frame timing from raw sync and data-enable,
// locks once the measurement repeats, and recovers pixel column/row addresses.
module vga_timing_detector #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        HSYNC_Sig,
  input  logic        VSYNC_Sig,
  input  logic        Ready_Sig,
  output logic        Ready_Out,
  output logic [10:0] Column_Addr_Sig,
  output logic [10:0] Row_Addr_Sig,
  output logic [11:0] H_Total,
  output logic [11:0] H_Active,
  output logic [11:0] V_Total,
  output logic [11:0] V_Active,
  output logic        Locked,
  output logic        Frame_Start
);

  localparam logic [3:0]  LF  = 4'(LOCK_FRAMES);
  localparam logic [11:0] MAX = 12'hFFF;

  typedef enum logic [1:0] {S_SEARCH, S_MEASURE, S_LOCKED} state_t;

  typedef struct packed {
    logic [11:0] ht;
    logic [11:0] ha;
    logic [11:0] vt;
    logic [11:0] va;
  } meas_t;

  // input capture and edge history
  logic r_hs, r_vs, r_rdy, r_hs_d, r_vs_d;

  // measurement counters
  logic [11:0] r_h_cnt, r_pix_cnt, r_hper, r_hact, r_v_cnt, r_act_cnt;

  // lock tracking
  state_t      r_state;
  meas_t       r_prev;
  logic [3:0]  r_match;

  logic        w_hfall, w_vfall, w_los, w_line_act;
  logic [11:0] w_hper_n, w_hact_n, w_vcnt_n, w_act_n, w_col, w_row;
  logic [3:0]  w_match_inc;
  meas_t       w_snap;

  function automatic logic [10:0] sat11(input logic [11:0] v);
    return v[11] ? 11'h7FF : v[10:0];
  endfunction

  assign w_hfall    = r_hs_d & ~r_hs;
  assign w_vfall    = r_vs_d & ~r_vs;
  assign w_los      = (r_h_cnt == MAX);
  assign w_line_act = (r_pix_cnt != 12'd0);

  // Values as they stand after this cycle's hfall, so a vfall landing on the
  // same cycle closes the frame with that line already counted.
  assign w_hper_n = w_hfall ? r_h_cnt : r_hper;
  assign w_hact_n = w_hfall ? r_pix_cnt : r_hact;
  assign w_vcnt_n = (w_hfall && r_v_cnt != MAX) ? r_v_cnt + 12'd1 : r_v_cnt;
  assign w_act_n  = (w_hfall && w_line_act && r_act_cnt != MAX) ? r_act_cnt + 12'd1 : r_act_cnt;
  assign w_snap   = '{ht: w_hper_n, ha: w_hact_n, vt: w_vcnt_n, va: w_act_n};

  // A pixel on the hfall cycle is the first of the new line; one on the vfall
  // cycle belongs to the new frame.
  assign w_col       = w_hfall ? 12'd0 : r_pix_cnt;
  assign w_row       = w_vfall ? 12'd0 : w_act_n;
  assign w_match_inc = r_match + 4'd1;

  // Register inputs once, then keep a delayed copy for edge detection
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_hs   <= 1'b0;
      r_vs   <= 1'b0;
      r_rdy  <= 1'b0;
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
    end else begin
      r_hs   <= HSYNC_Sig;
      r_vs   <= VSYNC_Sig;
      r_rdy  <= Ready_Sig;
      r_hs_d <= r_hs;
      r_vs_d <= r_vs;
    end
  end

  // Line/frame measurement counters; h_cnt saturates so a dead HSYNC is visible
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_h_cnt   <= '0;
      r_pix_cnt <= '0;
      r_hper    <= '0;
      r_hact    <= '0;
      r_v_cnt   <= '0;
      r_act_cnt <= '0;
    end else begin
      if (w_hfall) begin
        r_h_cnt   <= 12'd1;
        r_pix_cnt <= {11'd0, r_rdy};
      end else begin
        if (r_h_cnt != MAX) r_h_cnt <= r_h_cnt + 12'd1;
        if (r_rdy && r_pix_cnt != MAX) r_pix_cnt <= r_pix_cnt + 12'd1;
      end
      r_hper <= w_hper_n;
      r_hact <= w_hact_n;
      if (w_vfall) begin
        r_v_cnt   <= '0;
        r_act_cnt <= '0;
      end else begin
        r_v_cnt   <= w_vcnt_n;
        r_act_cnt <= w_act_n;
      end
    end
  end

  // Pixel address recovery, two cycles behind Ready_Sig, independent of lock
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      Ready_Out       <= 1'b0;
      Column_Addr_Sig <= '0;
      Row_Addr_Sig    <= '0;
    end else begin
      Ready_Out       <= r_rdy;
      Column_Addr_Sig <= r_rdy ? sat11(w_col) : 11'd0;
      Row_Addr_Sig    <= r_rdy ? sat11(w_row) : 11'd0;
    end
  end

  // Lock FSM: compare per-frame snapshots, load timing outputs on lock
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_state     <= S_SEARCH;
      r_prev      <= '0;
      r_match     <= '0;
      Locked      <= 1'b0;
      Frame_Start <= 1'b0;
      H_Total     <= '0;
      H_Active    <= '0;
      V_Total     <= '0;
      V_Active    <= '0;
    end else begin
      Frame_Start <= w_vfall;
      if (w_los) begin
        r_state <= S_SEARCH;
        r_match <= '0;
        Locked  <= 1'b0;
      end else if (w_vfall) begin
        r_prev <= w_snap;
        case (r_state)
          S_SEARCH: begin
            r_match <= '0;
            r_state <= S_MEASURE;
          end
          S_MEASURE: begin
            if (w_snap == r_prev) begin
              r_match <= w_match_inc;
              if (w_match_inc >= LF) begin
                r_state  <= S_LOCKED;
                Locked   <= 1'b1;
                H_Total  <= w_snap.ht;
                H_Active <= w_snap.ha;
                V_Total  <= w_snap.vt;
                V_Active <= w_snap.va;
              end
            end else begin
              r_match <= '0;
            end
          end
          S_LOCKED: begin
            if (w_snap != r_prev) begin
              r_state <= S_SEARCH;
              r_match <= '0;
              Locked  <= 1'b0;
            end
          end
          default: begin
            r_state <= S_SEARCH;
            r_match <= '0;
            Locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_detector.sv
// Scoreboard bench for vga_timing_detector: stimulus pushes expected pixel
// addresses and per-frame timing results; a negedge monitor pops and compares.
module tb_vga_timing_detector;

  logic        vga_clk = 1'b0;
  logic        rst;
  logic        HSYNC_Sig, VSYNC_Sig, Ready_Sig;
  logic        Ready_Out, Locked, Frame_Start;
  logic [10:0] Column_Addr_Sig, Row_Addr_Sig;
  logic [11:0] H_Total, H_Active, V_Total, V_Active;

  typedef struct {
    logic        lk;
    logic [11:0] ht, ha, vt, va;
  } fexp_t;

  typedef struct {
    logic [10:0] c, r;
  } pexp_t;

  fexp_t fq[$];
  pexp_t pq[$];
  int    checks   = 0;
  int    failures = 0;
  logic  h1 = 1'b0, h2 = 1'b0;

  vga_timing_detector #(.LOCK_FRAMES(2)) dut (
    .vga_clk(vga_clk), .rst(rst), .HSYNC_Sig(HSYNC_Sig), .VSYNC_Sig(VSYNC_Sig),
    .Ready_Sig(Ready_Sig), .Ready_Out(Ready_Out), .Column_Addr_Sig(Column_Addr_Sig),
    .Row_Addr_Sig(Row_Addr_Sig), .H_Total(H_Total), .H_Active(H_Active),
    .V_Total(V_Total), .V_Active(V_Active), .Locked(Locked), .Frame_Start(Frame_Start)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  // Frame = lead blank lines, 12 active lines, 1 blank line carrying VSYNC.
  // Line: 100 cycles, HSYNC low 0..9, Ready 20..83, VSYNC falls at vs_off.
  task automatic send_lines(input int lead, input int first, input int last,
                            input int vs_off, input fexp_t e);
    int total;
    logic vsl, act;
    total = lead + 13;
    for (int ln = first; ln <= last; ln++) begin
      for (int c = 0; c < 100; c++) begin
        vsl = (ln == total - 1);
        act = (ln >= lead) && (ln < lead + 12) && (c >= 20) && (c < 84);
        if (vsl && c == vs_off) fq.push_back(e);
        if (act) pq.push_back('{c: 11'(c - 20), r: 11'(ln - lead)});
        HSYNC_Sig = (c >= 10);
        VSYNC_Sig = !(vsl && c >= vs_off && c < vs_off + 50);
        Ready_Sig = act;
        tick();
      end
    end
  endtask

  task automatic send_frame(input int lead, input int vs_off, input fexp_t e);
    send_lines(lead, 0, lead + 12, vs_off, e);
  endtask

  task automatic idle(input int n);
    HSYNC_Sig = 1'b1;
    VSYNC_Sig = 1'b1;
    Ready_Sig = 1'b0;
    repeat (n) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_locked"}, Locked, 0);
    chk({tag, "_fs"}, Frame_Start, 0);
    chk({tag, "_rdy"}, Ready_Out, 0);
    chk({tag, "_col"}, Column_Addr_Sig, 0);
    chk({tag, "_row"}, Row_Addr_Sig, 0);
    chk({tag, "_htot"}, H_Total, 0);
    chk({tag, "_hact"}, H_Active, 0);
    chk({tag, "_vtot"}, V_Total, 0);
    chk({tag, "_vact"}, V_Active, 0);
  endtask

  // Monitor: pixel scoreboard, Ready_Out delay, idle-zero addresses, frame results
  always @(negedge vga_clk) begin
    if (!rst) begin
      chk("ready_delay2", Ready_Out, h2);
      if (Ready_Out) begin
        checks++;
        if (pq.size() == 0) begin
          failures++;
          $display("FAIL pix_unexpected actual=pixel required=none t=%0t", $time);
        end else begin
          pexp_t p;
          p = pq.pop_front();
          chk("col", Column_Addr_Sig, p.c);
          chk("row", Row_Addr_Sig, p.r);
        end
      end else begin
        chk("addr_idle_zero", {Column_Addr_Sig, Row_Addr_Sig}, 0);
      end
      if (Frame_Start) begin
        checks++;
        if (fq.size() == 0) begin
          failures++;
          $display("FAIL frame_unexpected actual=pulse required=none t=%0t", $time);
        end else begin
          fexp_t f;
          f = fq.pop_front();
          chk("f_locked", Locked, f.lk);
          chk("f_htot", H_Total, f.ht);
          chk("f_hact", H_Active, f.ha);
          chk("f_vtot", V_Total, f.vt);
          chk("f_vact", V_Active, f.va);
        end
      end
    end
    h2 = h1;
    h1 = Ready_Sig;
  end

  initial begin
    fexp_t n0, l20, d20, l21, d21;
    n0  = '{lk: 1'b0, ht: 12'd0,   ha: 12'd0,  vt: 12'd0,  va: 12'd0};
    l20 = '{lk: 1'b1, ht: 12'd100, ha: 12'd64, vt: 12'd20, va: 12'd12};
    d20 = '{lk: 1'b0, ht: 12'd100, ha: 12'd64, vt: 12'd20, va: 12'd12};
    l21 = '{lk: 1'b1, ht: 12'd100, ha: 12'd64, vt: 12'd21, va: 12'd12};
    d21 = '{lk: 1'b0, ht: 12'd100, ha: 12'd64, vt: 12'd21, va: 12'd12};

    rst = 1'b1;
    idle(3);
    @(negedge vga_clk);
    check_reset_outputs("por");
    tick();
    rst = 1'b0;
    idle(5);

    // Stable 20-line timing: lock on the third vfall
    send_frame(7, 5, n0);
    send_frame(7, 5, n0);
    send_frame(7, 5, l20);
    send_frame(7, 5, l20);

    // One 21-line frame drops lock with outputs held; relock on 21-line timing
    send_frame(8, 5, d20);
    send_frame(8, 5, d20);
    send_frame(8, 5, d20);
    send_frame(8, 5, l21);

    // Loss of HSYNC forces search; timing restart relocks on the third vfall
    idle(4200);
    @(negedge vga_clk);
    chk("los_locked", Locked, 0);
    chk("los_vtot_hold", V_Total, 21);
    tick();
    send_frame(7, 5, d21);
    send_frame(7, 5, d21);
    send_frame(7, 5, l20);

    // Mid-frame reset while locked, then relock with coincident hsync/vsync edges
    send_lines(7, 0, 3, 0, n0);
    rst = 1'b1;
    tick();
    @(negedge vga_clk);
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    idle(5);
    send_lines(7, 5, 19, 0, n0);
    send_frame(7, 0, n0);
    send_frame(7, 0, n0);
    send_frame(7, 0, l20);

    idle(10);
    chk("pix_queue_drained", pq.size(), 0);
    chk("frame_queue_drained", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
